enc_session_ctrl: RTL and testbench
===================================

ENC_SESSION_CTRL -- requirements
Module: enc_session_ctrl

Interface
REQ-001 Parameter LATENCY, default 5, meaning enabled clock edges before the datapath's true/c2 outputs are valid.
REQ-002 Parameter ERR_W, default 8, meaning width of the error counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  requester offers an operand set.
REQ-006 req_ready  out  1  controller can accept an operand set.
REQ-007 req_r1, req_r2, req_c1, req_p  in  32 each  operand set.
REQ-008 req_exp  in  64  exponent value to reduce mod p.
REQ-009 enc_r1, enc_r2, enc_c1, enc_p  out  32 each  registered operands to the datapath.
REQ-010 enc_exp  out  64  registered exponent to the datapath.
REQ-011 enc_en  out  1  datapath enable; drives the datapath's done_i_enc2.
REQ-012 enc_true  in  1  datapath verification flag.
REQ-013 enc_c2  in  32  datapath result.
REQ-014 rsp_valid  out  1  result available.
REQ-015 rsp_ready  in  1  requester takes the result.
REQ-016 rsp_ok  out  1  1 = verified, 0 = mismatch or p==0.
REQ-017 rsp_c2  out  32  result; 0 when rsp_ok=0.
REQ-018 abort  in  1  cancel the current session.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 err_cnt  out  ERR_W  saturating count of failed sessions.

Function
REQ-021 States: IDLE, RUN, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE, req_valid=1, abort=0, req_p!=0: capture all operands into enc_*, clear cnt, go to RUN, enc_en=1 from the next cycle.
REQ-023 IDLE, req_valid=1, abort=0, req_p==0: no datapath enable; load rsp_ok=0 and rsp_c2=0, increment err_cnt, go to RESP.
REQ-024 RUN: enc_en=1, operands held stable, and cnt increments every edge.
REQ-025 RUN with cnt==LATENCY: sample enc_true into rsp_ok and enc_c2 into rsp_c2 (0 if enc_true=0), clear enc_en, and go to RESP on that edge.
REQ-026 Accept-to-rsp_valid latency SHALL be LATENCY+2 edges.
REQ-027 RESP: rsp_valid=1 with rsp_ok/rsp_c2 held until rsp_ready=1, then go to IDLE on that edge.
REQ-028 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-029 Each captured rsp_ok=0 SHALL increment err_cnt, saturating at 2^ERR_W-1 with no wrap.
REQ-030 abort=1 in any state: go to IDLE next edge, enc_en=0, rsp_valid=0, no response, err_cnt unchanged.
REQ-031 abort together with req_valid in IDLE: abort wins, nothing accepted.
REQ-032 abort together with rsp_ready in RESP: response counts as consumed, go to IDLE.
REQ-033 cnt SHALL be wide enough for LATENCY and SHALL not wrap inside RUN.

Reset
REQ-034 On rst=0, state=IDLE, enc_en=0, all enc_* operand outputs=0, rsp_valid=0, rsp_ok=0, rsp_c2=0, err_cnt=0, and cnt=0.
REQ-035 busy=0 and req_ready=1 from the first cycle after reset release.
REQ-036 Reset asserted mid-RUN SHALL drop enc_en immediately (asynchronously) and discard the session.

Structure
REQ-037 Package enc_ctrl_pkg SHALL hold the state enumeration, the LATENCY default and the ERR_W default.
REQ-038 The saturating error counter SHALL be a sub-module, enc_err_counter, with inputs clk, rst and inc, and a count output.
REQ-039 All outputs except req_ready and busy SHALL be registered; req_ready and busy decode state.

Verification
REQ-040 Nominal: p=7, exp=100 (k=2), c1=5, r2=7, r1=9 -> rsp_valid at accept+7 edges, rsp_ok=1, rsp_c2=11, err_cnt=0.
REQ-041 Mismatch: same operands with r2=8 -> rsp_ok=0, rsp_c2=0, err_cnt=1.
REQ-042 Divide guard: p=0 -> RESP one edge after accept, enc_en never high, rsp_ok=0, err_cnt increments.
REQ-043 Backpressure: rsp_ready low for 10 cycles -> rsp_valid/rsp_c2 stable, req_ready=0, second req_valid not accepted until one edge after rsp_ready.
REQ-044 Abort at cnt=3 -> enc_en=0 next cycle, no rsp_valid, req_ready=1, err_cnt unchanged; then a nominal request completes correctly.
REQ-045 Reset mid-RUN and err_cnt saturation with ERR_W=2 -> all outputs take reset values; four failures leave err_cnt=3.

Source files
------------

// File: rtl/enc_session_ctrl_pkg.sv
// Shared types and defaults for the encryption session controller.
// Holds the controller state encoding and the default latency/counter widths.
package enc_ctrl_pkg;

    localparam int LATENCY_DEF = 5;
    localparam int ERR_W_DEF   = 8;
    localparam int DATA_W      = 32;
    localparam int EXP_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/enc_session_ctrl_if.sv
// Requester-side bus of the session controller: operand request channel and result channel.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; the
// sender holds valid and its payload steady until that edge, and ready never waits on valid.
interface enc_session_ctrl_if;
    import enc_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_r1;
    logic [DATA_W-1:0] req_r2;
    logic [DATA_W-1:0] req_c1;
    logic [DATA_W-1:0] req_p;
    logic [EXP_W-1:0]  req_exp;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_ok;
    logic [DATA_W-1:0] rsp_c2;

    modport master (
        output req_valid, req_r1, req_r2, req_c1, req_p, req_exp, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_c2
    );

    modport slave (
        input  req_valid, req_r1, req_r2, req_c1, req_p, req_exp, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_c2
    );

endinterface

// File: rtl/enc_session_ctrl_err_counter.sv
// Saturating count of failed sessions; holds at all-ones instead of wrapping.
module enc_err_counter
    import enc_ctrl_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ERR_W'(1);
        end
    end

endmodule

// File: rtl/enc_session_ctrl.sv
// Session controller: accepts an operand set, runs the datapath for LATENCY enabled edges,
// then returns a verified result (or a failure) over the response channel.
module enc_session_ctrl
    import enc_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int ERR_W   = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    enc_session_ctrl_if.slave  bus,
    output logic [DATA_W-1:0]  enc_r1,
    output logic [DATA_W-1:0]  enc_r2,
    output logic [DATA_W-1:0]  enc_c1,
    output logic [DATA_W-1:0]  enc_p,
    output logic [EXP_W-1:0]   enc_exp,
    output logic               enc_en,
    input  logic               enc_true,
    input  logic [DATA_W-1:0]  enc_c2,
    input  logic               abort,
    output logic               busy,
    output logic [ERR_W-1:0]   err_cnt,
    output state_t             state_dbg
);

    // cnt must reach LATENCY without wrapping, so size it for LATENCY itself
    localparam int              CNT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              guard;
    logic              finish;
    logic              rsp_valid_q;
    logic              rsp_ok_q;
    logic [DATA_W-1:0] rsp_c2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort overrides every other transition, including a pending accept or consume
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        guard     = 1'b0;
        finish    = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_p != '0) begin
                            accept    = 1'b1;
                            state_nxt = ST_RUN;
                        end else begin
                            guard     = 1'b1;
                            state_nxt = ST_RESP;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_LAST) begin
                        finish    = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_r1      <= '0;
            enc_r2      <= '0;
            enc_c1      <= '0;
            enc_p       <= '0;
            enc_exp     <= '0;
            enc_en      <= 1'b0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_c2_q    <= '0;
        end else begin
            if (accept) begin
                enc_r1  <= bus.req_r1;
                enc_r2  <= bus.req_r2;
                enc_c1  <= bus.req_c1;
                enc_p   <= bus.req_p;
                enc_exp <= bus.req_exp;
            end

            if (accept) begin
                cnt <= '0;
            end else if ((state == ST_RUN) && !finish && !abort) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                enc_en <= 1'b1;
            end else if (finish || abort) begin
                enc_en <= 1'b0;
            end

            if (guard || finish) begin
                rsp_valid_q <= 1'b1;
            end else if (abort || ((state == ST_RESP) && bus.rsp_ready)) begin
                rsp_valid_q <= 1'b0;
            end

            // a failed verification never exposes the datapath's partial result
            if (guard) begin
                rsp_ok_q <= 1'b0;
                rsp_c2_q <= '0;
            end else if (finish) begin
                rsp_ok_q <= enc_true;
                rsp_c2_q <= enc_true ? enc_c2 : '0;
            end
        end
    end

    enc_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (guard | (finish & ~enc_true)),
        .count (err_cnt)
    );

    assign bus.req_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ok    = rsp_ok_q;
    assign bus.rsp_c2    = rsp_c2_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_enc_session_ctrl.sv
// Directed bench for enc_session_ctrl: behavioural datapath stub, expected-result queue,
// and a second instance with a 2-bit error counter for saturation.
module tb_enc_session_ctrl;
  import enc_ctrl_pkg::*;

  localparam int LAT = 5;

  logic clk;
  logic rst;

  // ---------------- main instance ----------------
  enc_session_ctrl_if bus ();
  logic [31:0] enc_r1, enc_r2, enc_c1, enc_p, enc_c2;
  logic [63:0] enc_exp;
  logic        enc_en, enc_true, abort, busy;
  logic [7:0]  err_cnt;
  state_t      state_dbg;

  enc_session_ctrl #(.LATENCY(LAT), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .enc_r1    (enc_r1),
    .enc_r2    (enc_r2),
    .enc_c1    (enc_c1),
    .enc_p     (enc_p),
    .enc_exp   (enc_exp),
    .enc_en    (enc_en),
    .enc_true  (enc_true),
    .enc_c2    (enc_c2),
    .abort     (abort),
    .busy      (busy),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- saturation instance ----------------
  enc_session_ctrl_if bus2 ();
  logic [31:0] s_r1, s_r2, s_c1, s_p;
  logic [63:0] s_exp;
  logic        s_en, s_busy;
  logic [1:0]  s_err;
  state_t      s_state;
  logic        s_true, s_abort;
  logic [31:0] s_c2;

  enc_session_ctrl #(.LATENCY(2), .ERR_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .enc_r1    (s_r1),
    .enc_r2    (s_r2),
    .enc_c1    (s_c1),
    .enc_p     (s_p),
    .enc_exp   (s_exp),
    .enc_en    (s_en),
    .enc_true  (s_true),
    .enc_c2    (s_c2),
    .abort     (s_abort),
    .busy      (s_busy),
    .err_cnt   (s_err),
    .state_dbg (s_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath stub ----------------
  // Outputs are garbage until LAT enabled edges have elapsed; then c2 = r1 + (exp mod p),
  // true when r2 is a multiple of p.
  int unsigned dp_cnt;
  logic [63:0] dp_k;

  always @(posedge clk or negedge rst) begin
    if (!rst) dp_cnt <= 0;
    else if (enc_en) dp_cnt <= dp_cnt + 1;
    else dp_cnt <= 0;
  end

  always_comb begin
    dp_k     = 64'd0;
    enc_true = 1'b0;
    enc_c2   = 32'hDEAD_BEEF;
    if ((dp_cnt >= LAT) && (enc_p != 32'd0)) begin
      dp_k     = enc_exp % {32'd0, enc_p};
      enc_true = ((enc_r2 % enc_p) == 32'd0);
      enc_c2   = enc_r1 + dp_k[31:0];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] c1,
                          input logic [31:0] p, input logic [63:0] ex, output bit acc);
    bit rdy;
    bus.req_r1 = r1; bus.req_r2 = r2; bus.req_c1 = c1; bus.req_p = p; bus.req_exp = ex;
    bus.req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      rdy = bus.req_ready && !abort;
      tick();
      if (rdy) acc = 1'b1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic consume(input string tag);
    logic [32:0] e;
    check_eq({tag, "_sb_avail"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_rsp_ok"}, 64'(bus.rsp_ok), 64'(e[32]));
      check_eq({tag, "_rsp_c2"}, 64'(bus.rsp_c2), 64'(e[31:0]));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq({tag, "_rsp_valid_drop"}, 64'(bus.rsp_valid), 64'd0);
    check_eq({tag, "_req_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic run_session(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] c1, input logic [31:0] p, input logic [63:0] ex,
                             input logic exp_ok, input logic [31:0] exp_c2, input int exp_lat,
                             input logic [7:0] exp_err);
    bit acc;
    int n;
    exp_q.push_back({exp_ok, exp_c2});
    send_req(r1, r2, c1, p, ex, acc);
    check_eq({tag, "_accepted"}, 64'(acc), 64'd1);
    check_eq({tag, "_enc_en"}, 64'(enc_en), 64'(p != 32'd0));
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    if (p != 32'd0) check_eq({tag, "_enc_p"}, 64'(enc_p), 64'(p));
    wait_rsp(n);
    check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
    consume(tag);
    check_eq({tag, "_enc_en_off"}, 64'(enc_en), 64'd0);
    check_eq({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int n;

    rst = 1'b0;
    abort = 1'b0;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req_r1 = '0; bus.req_r2 = '0; bus.req_c1 = '0; bus.req_p = '0; bus.req_exp = '0;
    bus2.req_valid = 1'b0; bus2.rsp_ready = 1'b0;
    bus2.req_r1 = '0; bus2.req_r2 = '0; bus2.req_c1 = '0; bus2.req_p = '0; bus2.req_exp = '0;
    s_true = 1'b0; s_c2 = '0; s_abort = 1'b0;

    // reset values
    repeat (3) tick();
    check_eq("rst_enc_en", 64'(enc_en), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_ok", 64'(bus.rsp_ok), 64'd0);
    check_eq("rst_rsp_c2", 64'(bus.rsp_c2), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("rst_enc_exp", enc_exp, 64'd0);
    check_eq("rst_enc_r1", 64'(enc_r1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("post_rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // nominal, mismatch, divide guard
    run_session("nominal", 32'd9, 32'd7, 32'd5, 32'd7, 64'd100, 1'b1, 32'd11, LAT + 2, 8'd0);
    run_session("mismatch", 32'd9, 32'd8, 32'd5, 32'd7, 64'd100, 1'b0, 32'd0, LAT + 2, 8'd1);
    run_session("p_zero", 32'd9, 32'd7, 32'd5, 32'd0, 64'd100, 1'b0, 32'd0, 1, 8'd2);

    // backpressure with a second request waiting
    exp_q.push_back({1'b1, 32'd11});
    exp_q.push_back({1'b0, 32'd0});
    send_req(32'd9, 32'd7, 32'd5, 32'd7, 64'd100, acc);
    check_eq("bp_accepted", 64'(acc), 64'd1);
    wait_rsp(n);
    check_eq("bp_latency", 64'(n), 64'(LAT + 2));
    bus.req_r1 = 32'd9; bus.req_r2 = 32'd8; bus.req_c1 = 32'd5; bus.req_p = 32'd7;
    bus.req_exp = 64'd100;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
      check_eq("bp_rsp_c2_hold", 64'(bus.rsp_c2), 64'd11);
      check_eq("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
    end
    consume("bp_first");
    check_eq("bp_not_yet_accepted", 64'(busy), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    check_eq("bp_second_accepted", 64'(state_dbg), 64'(ST_RUN));
    check_eq("bp_second_enc_r2", 64'(enc_r2), 64'd8);
    wait_rsp(n);
    check_eq("bp_second_latency", 64'(n), 64'(LAT + 2));
    consume("bp_second");
    check_eq("bp_err_cnt", 64'(err_cnt), 64'd3);

    // abort at cnt=3
    send_req(32'd9, 32'd7, 32'd5, 32'd7, 64'd100, acc);
    check_eq("abort_accepted", 64'(acc), 64'd1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_enc_en", 64'(enc_en), 64'd0);
    check_eq("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("abort_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("abort_err_cnt", 64'(err_cnt), 64'd3);
    repeat (8) tick();
    check_eq("abort_no_rsp_later", 64'(bus.rsp_valid), 64'd0);
    run_session("after_abort", 32'd9, 32'd7, 32'd5, 32'd7, 64'd100, 1'b1, 32'd11, LAT + 2, 8'd3);

    // abort beats req_valid in IDLE
    bus.req_p = 32'd7; bus.req_valid = 1'b1; abort = 1'b1;
    tick();
    bus.req_valid = 1'b0; abort = 1'b0;
    check_eq("abort_idle_busy", 64'(busy), 64'd0);
    check_eq("abort_idle_enc_en", 64'(enc_en), 64'd0);

    // abort together with rsp_ready in RESP; the failure was already counted at capture
    send_req(32'd9, 32'd8, 32'd5, 32'd7, 64'd100, acc);
    wait_rsp(n);
    check_eq("abort_resp_latency", 64'(n), 64'(LAT + 2));
    check_eq("abort_resp_err_cnt", 64'(err_cnt), 64'd4);
    abort = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    abort = 1'b0; bus.rsp_ready = 1'b0;
    check_eq("abort_resp_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("abort_resp_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("abort_resp_err_keep", 64'(err_cnt), 64'd4);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 4; i++) begin
      bus2.req_p = 32'd0; bus2.req_valid = 1'b1;
      tick();
      bus2.req_valid = 1'b0;
      check_eq("sat_rsp_valid", 64'(bus2.rsp_valid), 64'd1);
      check_eq("sat_en_low", 64'(s_en), 64'd0);
      bus2.rsp_ready = 1'b1;
      tick();
      bus2.rsp_ready = 1'b0;
      check_eq("sat_err_cnt", 64'(s_err), (i < 3) ? 64'(i + 1) : 64'd3);
    end

    // reset mid-RUN
    send_req(32'd9, 32'd7, 32'd5, 32'd7, 64'd100, acc);
    repeat (2) tick();
    check_eq("midrun_enc_en_before", 64'(enc_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrun_enc_en_async", 64'(enc_en), 64'd0);
    check_eq("midrun_state", 64'(state_dbg), 64'(ST_IDLE));
    check_eq("midrun_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("midrun_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("midrun_enc_p", 64'(enc_p), 64'd0);
    check_eq("midrun_sat_err", 64'(s_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("midrun_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("midrun_busy", 64'(busy), 64'd0);
    run_session("after_reset", 32'd9, 32'd7, 32'd5, 32'd7, 64'd100, 1'b1, 32'd11, LAT + 2, 8'd0);

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
